reg_status_table: RTL

- Register status table plus architectural register file for the 16-bit out-of-order core.
- Sits upstream of the ROB, in dispatch. Each dispatched instruction gets either a ready value or the ROB tag of its producer for each source operand.
- Records the new instruction's ROB tag as the pending producer of its destination register.
- Downstream, it consumes ROB commits: writes the architectural value and clears the pending mapping when the tags still match.

---
 rtl/reg_status_table_pkg.sv | 25 ++
 rtl/rst_src_lookup.sv | 34 +++
 rtl/reg_status_table.sv | 118 +++++++++++
 3 files changed

// File: rtl/reg_status_table_pkg.sv
// Processor-wide shared types and sizes for the 16-bit out-of-order core.
package reg_status_table_pkg;

    localparam int unsigned XLEN      = 16;
    localparam int unsigned TAGW      = 4;
    localparam int unsigned NREGS     = 16;
    localparam int unsigned REGW      = $clog2(NREGS);
    localparam int unsigned ROB_DEPTH = 1 << TAGW;

    typedef struct packed {
        logic            busy;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] val;
    } src_op_t;

    function automatic logic [TAGW:0] busy_popcount(input logic [NREGS-1:0] v);
        logic [TAGW:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            cnt = cnt + (TAGW + 1)'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rst_src_lookup.sv
// Combinational source-operand lookup with same-cycle commit bypass.
module rst_src_lookup
    import reg_status_table_pkg::*;
(
    input  logic [NREGS-1:0] busy_tbl,
    input  logic [TAGW-1:0]  tag_tbl [NREGS],
    input  logic [XLEN-1:0]  val_tbl [NREGS],
    input  logic [REGW-1:0]  rs,
    input  logic             commit_valid,
    input  logic             commit_we,
    input  logic [REGW-1:0]  commit_rt,
    input  logic [TAGW-1:0]  commit_tag,
    input  logic [XLEN-1:0]  commit_val,
    output src_op_t          src
);

    logic hit;

    assign hit = commit_valid && commit_we && (commit_rt == rs) && (commit_tag == tag_tbl[rs]);

    always_comb begin
        src     = '0;
        src.val = val_tbl[rs];
        if (busy_tbl[rs]) begin
            if (hit) begin
                src.val = commit_val;
            end else begin
                src.busy = 1'b1;
                src.tag  = tag_tbl[rs];
            end
        end
    end

endmodule

// File: rtl/reg_status_table.sv
// Register status table and architectural register file for dispatch.
// Optional RST_R0_ZERO_EN makes r0 a hardwired zero that is never busy.
module reg_status_table
    import reg_status_table_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            disp_valid,
    input  logic [REGW-1:0] disp_ra,
    input  logic [REGW-1:0] disp_rb,
    input  logic [REGW-1:0] disp_rt,
    input  logic            disp_rt_we,
    input  logic [TAGW-1:0] disp_tag,
    output logic            src_a_busy,
    output logic [TAGW-1:0] src_a_tag,
    output logic [XLEN-1:0] src_a_val,
    output logic            src_b_busy,
    output logic [TAGW-1:0] src_b_tag,
    output logic [XLEN-1:0] src_b_val,
    input  logic            commit_valid,
    input  logic [REGW-1:0] commit_rt,
    input  logic            commit_we,
    input  logic [TAGW-1:0] commit_tag,
    input  logic [XLEN-1:0] commit_val,
    input  logic            flush,
    output logic [TAGW:0]   inflight_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [TAGW-1:0]  tag_q [NREGS];
    logic [TAGW-1:0]  tag_d [NREGS];
    logic [XLEN-1:0]  val_q [NREGS];
    logic [XLEN-1:0]  val_d [NREGS];
    logic [TAGW:0]    cnt_q, cnt_d;
    logic             commit_en, disp_en;
    src_op_t          src_a, src_b;

    // A flush squashes the dispatching instruction, so it never claims its destination.
`ifdef RST_R0_ZERO_EN
    assign commit_en = commit_valid & commit_we & (commit_rt != '0);
    assign disp_en   = disp_valid & disp_rt_we & ~flush & (disp_rt != '0);
`else
    assign commit_en = commit_valid & commit_we;
    assign disp_en   = disp_valid & disp_rt_we & ~flush;
`endif

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        val_d  = val_q;
        if (commit_en) begin
            val_d[commit_rt] = commit_val;
            if (busy_q[commit_rt] && (tag_q[commit_rt] == commit_tag)) begin
                busy_d[commit_rt] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        // Dispatch applied last so a newer producer beats a same-cycle commit.
        if (disp_en) begin
            busy_d[disp_rt] = 1'b1;
            tag_d[disp_rt]  = disp_tag;
        end
        cnt_d = busy_popcount(busy_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                tag_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            tag_q  <= tag_d;
            val_q  <= val_d;
        end
    end

    rst_src_lookup u_lookup_a (
        .busy_tbl     (busy_q),
        .tag_tbl      (tag_q),
        .val_tbl      (val_q),
        .rs           (disp_ra),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_rt    (commit_rt),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .src          (src_a)
    );

    rst_src_lookup u_lookup_b (
        .busy_tbl     (busy_q),
        .tag_tbl      (tag_q),
        .val_tbl      (val_q),
        .rs           (disp_rb),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_rt    (commit_rt),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .src          (src_b)
    );

    assign src_a_busy   = src_a.busy;
    assign src_a_tag    = src_a.tag;
    assign src_a_val    = src_a.val;
    assign src_b_busy   = src_b.busy;
    assign src_b_tag    = src_b.tag;
    assign src_b_val    = src_b.val;
    assign inflight_cnt = cnt_q;

endmodule
